wb_uart_rx: RTL and testbench



---
 rtl/wb_uart_rx.sv | 115 +++++++++++
 tb/tb_wb_uart_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_rx.sv
// wb_uart_rx: 8N1 UART receiver with a one-byte holding register read over a Wishbone B4 subset port.
// Optional define UART_RX_MAJORITY_EN samples the 2-of-3 majority of the synchronised line.
module wb_uart_rx #(
  parameter int TICKS_PER_BAUD = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_stb_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  input  logic       uart_rx,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_ovr_o
);
  localparam int HALF = TICKS_PER_BAUD / 2;
  localparam int CW = $clog2(TICKS_PER_BAUD);
  localparam logic [CW-1:0] TOP = CW'(TICKS_PER_BAUD - 1);
  localparam logic [CW-1:0] MID = CW'(HALF - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, hold_q, hold_d, dat_q, dat_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, ack_q, ack_d;
  logic load, fe, rd;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  assign s = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) hist_q <= 2'b11;
    else hist_q <= {hist_q[0], sync2_q};
`else
  assign s = sync2_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh_d = sh_q;
    load = 1'b0;
    fe = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!sync2_q) state_d = START;
      end
      START:
        if (cnt_q == MID) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = s ? IDLE : DATA;
        end else cnt_d = cnt_q + 1'b1;
      DATA:
        if (cnt_q == TOP) begin
          cnt_d = '0;
          sh_d[idx_q] = s;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + 1'b1;
      STOP:
        if (cnt_q == TOP) begin
          cnt_d = '0;
          state_d = IDLE;
          load = s;
          fe = !s;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // A read on the same edge as a stop-bit load returns the old byte and leaves the new one pending.
  always_comb begin
    rd = wb_stb_i & ~ack_q;
    ack_d = rd;
    dat_d = rd ? hold_q : dat_q;
    hold_d = load ? sh_q : hold_q;
    valid_d = load | (valid_q & ~rd);
    ovr_d = (load & valid_q & ~rd) | (ovr_q & ~rd);
    ferr_d = fe | (ferr_q & ~rd);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      hold_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      hold_q <= hold_d;
      dat_q <= dat_d;
      ack_q <= ack_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o = ferr_q;
  assign rx_ovr_o = ovr_q;
endmodule

// File: tb/tb_wb_uart_rx.sv
// tb_wb_uart_rx: scoreboard bench for wb_uart_rx; frames are driven bit by bit and a monitor checks every ack.
module tb_wb_uart_rx;
  localparam int T = 16;
  localparam int HALF = T / 2;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0, rx = 1'b1;
  logic [7:0] dat;
  logic ack, vld, fe, ov;
  always #5 clk = ~clk;
  wb_uart_rx #(.TICKS_PER_BAUD(T)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_stb_i(stb), .wb_dat_o(dat), .wb_ack_o(ack),
    .uart_rx(rx), .rx_valid_o(vld), .rx_ferr_o(fe), .rx_ovr_o(ov)
  );
  typedef struct {logic [7:0] d; logic v, f, o;} exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0;
  logic [7:0] m_hold = 8'h00;
  logic m_v = 1'b0, m_f = 1'b0, m_o = 1'b0;
  logic prev_ack = 1'b0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      m_o = m_o | m_v;
      m_hold = b;
      m_v = 1'b1;
    end else m_f = 1'b1;
  endtask
  task automatic check_flags(input string n);
    chk({n, "_valid"}, vld, m_v);
    chk({n, "_ferr"}, fe, m_f);
    chk({n, "_ovr"}, ov, m_o);
  endtask
  task automatic frame_cycles(input logic [7:0] b, input logic stop, input int ncyc, input int g);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      rx = f[c / T] ^ (c == g);
      @(negedge clk);
    end
    rx = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    frame_cycles(b, stop, 10 * T, -1);
    model_frame(b, stop);
    check_flags("frame");
  endtask
  task automatic rd();
    q.push_back('{m_hold, 1'b0, 1'b0, 1'b0});
    m_v = 1'b0;
    m_f = 1'b0;
    m_o = 1'b0;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask
  always @(negedge clk) begin
    if (prev_ack) chk("ack_one_cycle", ack, 1'b0);
    if (ack) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 required=no ack at %0t", $time);
      end else begin
        me = q.pop_front();
        chk("read_data", dat, me.d);
        chk("read_valid", vld, me.v);
        chk("read_ferr", fe, me.f);
        chk("read_ovr", ov, me.o);
      end
    end
    prev_ack = ack;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    logic stop;
    repeat (3) @(negedge clk);
    chk("rst_dat", dat, 0);
    chk("rst_ack", ack, 0);
    check_flags("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fork
      frame_cycles(8'h55, 1'b1, 10 * T, -1);
      begin
        repeat (2 + HALF + 9 * T) @(negedge clk);
        chk("latency_before", vld, 0);
        @(negedge clk);
        chk("latency_after", vld, 1);
      end
    join
    model_frame(8'h55, 1'b1);
    check_flags("f55");
    rd();
    check_flags("rd55");
    send(8'h00, 1'b1);
    fork
      frame_cycles(8'hFF, 1'b1, 10 * T, -1);
      begin
        repeat (T) @(negedge clk);
        rd();
      end
    join
    model_frame(8'hFF, 1'b1);
    check_flags("fFF");
    rd();
    send(8'hA3, 1'b0);
    repeat (T) @(negedge clk);
    rd();
    check_flags("rd_ferr");
    frame_cycles(8'h00, 1'b1, 3, -1);
    repeat (2 * T) @(negedge clk);
    check_flags("short_glitch");
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rd();
    check_flags("rd_ovr");
    send(8'h44, 1'b1);
    q.push_back('{8'h44, 1'b1, 1'b0, 1'b0});
    fork
      frame_cycles(8'h77, 1'b1, 10 * T, -1);
      begin
        repeat (2 + HALF + 9 * T) @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
      end
    join
    m_hold = 8'h77;
    m_v = 1'b1;
    m_f = 1'b0;
    m_o = 1'b0;
    check_flags("same_edge");
    frame_cycles(8'h96, 1'b1, 5 * T + HALF, -1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dat", dat, 0);
    chk("midrst_ack", ack, 0);
    m_hold = 8'h00;
    m_v = 1'b0;
    m_f = 1'b0;
    m_o = 1'b0;
    check_flags("midrst");
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h3C, 1'b1);
    rd();
`ifdef UART_RX_MAJORITY_EN
    frame_cycles(8'h3C, 1'b1, 10 * T, HALF + 3 * T);
    model_frame(8'h3C, 1'b1);
    check_flags("maj");
    rd();
`endif
    for (int i = 0; i < 30; i++) begin
      stop = ($urandom_range(0, 5) != 0);
      send(8'($urandom_range(0, 255)), stop);
      if (!stop) repeat (T) @(negedge clk);
      else repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 2) != 0) begin
        rd();
        check_flags("rnd_rd");
      end
    end
    rd();
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
